dm_bytelane: RTL and testbench
==============================

# dm_bytelane

Parametrised successor to the single-cycle word data memory. It adds byte, halfword and word loads and stores with sign or zero extension, and detects misaligned accesses. It uses a registered read port with a valid strobe and a sequential zero-clear engine that runs after reset. It sits in the MEM stage of the CPU datapath, between the ALU address result and the writeback mux.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words. Storage holds `2**DEPTH_LOG2` words.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pc` input 32: PC of the requesting instruction; used only by the trace.
- `req` input 1: access request.
- `we` input 1: 1 = store, 0 = load.
- `size` input 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `sign_ext` input 1: for loads, 1 = sign-extend, 0 = zero-extend.
- `addr` input 32: byte address. Bits `[DEPTH_LOG2+1:2]` index the word; higher bits are ignored, so the address wraps.
- `wdata` input 32: store data, taken from the low-aligned bits (byte `[7:0]`, half `[15:0]`).
- `ready` output 1: block accepts a request this cycle.
- `rvalid` output 1: one-cycle strobe qualifying `rdata` and `misalign`.
- `rdata` output 32: extended load result.
- `misalign` output 1: the accepted access was misaligned or illegal.

## Operation
- States: `CLEAR`, `RUN`.
- **Reset assertion** (asynchronous, while `reset_n`=0):
  - State goes to `CLEAR` and the clear pointer goes to 0.
  - `ready`, `rvalid`, `misalign` = 0; `rdata` = 0.
- **`CLEAR` state:**
  - Each cycle with `reset_n`=1, write 0 to `mem[ptr]` and increment `ptr`.
  - After the write to index `2**DEPTH_LOG2-1`, go to `RUN`.
  - `ready` = 0 throughout; requests are ignored, not queued.
- **`RUN` state:** `ready` = 1. A request is accepted on a rising edge with `req`=1.
- **Alignment check:**
  - Half with `addr[0]`=1 is misaligned.
  - Word with `addr[1:0]`≠0 is misaligned.
  - `size`=11 is always illegal.
  - A faulting store writes nothing. A faulting load returns `rdata`=0.
  - Either kind of fault gives `rvalid`=1 and `misalign`=1 for one cycle.
- **Store:**
  - Byte writes lane `addr[1:0]`.
  - Half writes lanes {1,0} when `addr[1]`=0, or lanes {3,2} when `addr[1]`=1.
  - Word writes all lanes.
  - Unselected lanes keep their contents.
  - A legal store does not assert `rvalid`.
- **Load:**
  - Read the word and select the lane or half given by `addr[1:0]`.
  - Extend according to `sign_ext`; `sign_ext` is ignored for words.
  - Register the result into `rdata` and pulse `rvalid`.
- `rdata` holds its value after a load until the next load or fault updates it.
- A reset arriving during `CLEAR` or mid-`RUN` restarts the clear from index 0. Memory contents are then all zero once `CLEAR` completes.

## Timing
- Store commits at the accepting edge.
- Load latency is 1 cycle: `rvalid`/`rdata` are valid in the cycle after acceptance.
- Throughput is one access per cycle.
- A store at edge N followed by a load of the same word at edge N+1 returns the new data. There is no bypass hazard, because the read occurs at the later edge.
- `ready` rises exactly `2**DEPTH_LOG2` cycles after the first rising edge with `reset_n`=1.
- `rvalid` and `misalign` are high for exactly one cycle per accepted load or fault.

## Configuration
- `DM_TRACE_EN` defined:
  - Every committed store prints `@<pc>: *<addr> <= <data>` in hex, where `<data>` is the full post-merge word and `<addr>` is the word-aligned address.
  - Faults print `@<pc>: misaligned <addr>`.
- `DM_TRACE_EN` undefined: no `$display` is emitted and RTL behaviour is otherwise identical.

## Test plan
- **Reset and clear:** release `reset_n` with `DEPTH_LOG2`=10.
  - `ready`=0 for 1024 cycles, then 1.
  - Load word at 0xFFC returns `rdata`=0x00000000 with `rvalid` one cycle later.
- **Load extension:** store word 0x12345678 at 0x10, then load:
  - Byte at 0x11 signed → 0x00000056.
  - Byte at 0x13 unsigned → 0x00000012.
  - Half at 0x12 → 0x00001234.
  - Word at 0x10 → 0x12345678.
- **Partial stores:**
  - Store byte 0xAB at 0x21 over a zero word; load word 0x20 → 0x0000AB00. Signed byte load at 0x21 → 0xFFFFFFAB.
  - Store half 0x8001 at 0x22; signed half load → 0xFFFF8001.
- **Faults:**
  - Load word at 0x06 → `rvalid`=1, `misalign`=1, `rdata`=0.
  - Store half at 0x03 → `misalign`=1 and memory is unchanged.
  - `size`=11 → `misalign`=1.
- **Wrap and back-to-back:**
  - Store word 0xDEADBEEF at 0x1010, then load word 0x0010 on the next cycle → 0xDEADBEEF.
- **Reset mid-clear:**
  - Drop `reset_n` at clear cycle 500 → `ready`/`rvalid`/`rdata` are 0 immediately.
  - After release, `ready` stays 0 for 1024 more cycles.
  - A previously written word reads back 0.

Source files
------------

// File: rtl/dm_bytelane.sv
// rtl/dm_bytelane.sv - byte-lane data memory with registered load port and post-reset zero-clear engine.
// Optional store/fault trace enabled by defining DM_TRACE_EN.
module dm_bytelane #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        misalign
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic                  r_ready;
  logic                  r_rvalid;
  logic                  r_misalign;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_word;
  logic [31:0]           w_shift;
  logic [15:0]           w_half;
  logic [3:0]            w_be;
  logic [31:0]           w_wrep;
  logic [31:0]           w_merged;
  logic [31:0]           w_load;
  logic                  w_fault;
  logic                  w_accept;
  logic                  w_st_we;
  logic                  w_clr_we;
  logic                  w_unused;

  assign w_idx    = addr[DEPTH_LOG2+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_shift  = w_word >> {addr[1:0], 3'b000};
  assign w_half   = addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_accept = (r_state == S_RUN) && req;
  assign w_st_we  = w_accept && we && !w_fault;
  assign w_clr_we = (r_state == S_CLEAR) && reset_n;
  // pc only feeds the trace; upper address bits are dropped so the address wraps
  assign w_unused = ^{pc, addr[31:DEPTH_LOG2+2]};

  always_comb begin
    w_fault = 1'b0;
    case (size)
      2'b00:   w_fault = 1'b0;
      2'b01:   w_fault = addr[0];
      2'b10:   w_fault = (addr[1:0] != 2'b00);
      default: w_fault = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the destination
  always_comb begin
    w_be   = 4'b1111;
    w_wrep = wdata;
    case (size)
      2'b00: begin
        w_be   = 4'b0001 << addr[1:0];
        w_wrep = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be   = addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wrep = wdata;
      end
    endcase
  end

  always_comb begin
    w_merged = w_word;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_merged[8*i +: 8] = w_wrep[8*i +: 8];
    end
  end

  always_comb begin
    w_load = w_word;
    case (size)
      2'b00:   w_load = sign_ext ? {{24{w_shift[7]}}, w_shift[7:0]} : {24'h0, w_shift[7:0]};
      2'b01:   w_load = sign_ext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      default: w_load = w_word;
    endcase
  end

  // Storage has no reset; the clear engine zeroes it one word per cycle instead
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_ptr] <= '0;
    end else if (w_st_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_CLEAR;
      r_ptr      <= '0;
      r_ready    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == {DEPTH_LOG2{1'b1}}) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (req) begin
            if (w_fault) begin
              r_rvalid   <= 1'b1;
              r_misalign <= 1'b1;
              r_rdata    <= '0;
            end else if (!we) begin
              r_rvalid <= 1'b1;
              r_rdata  <= w_load;
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset_n && w_accept) begin
      if (w_fault)
        $display("@%h: misaligned %h", pc, addr);
      else if (we)
        $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, w_merged);
    end
  end
`else
`endif

  assign ready    = r_ready;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign misalign = r_misalign;

endmodule

// File: tb/tb_dm_bytelane.sv
// tb/tb_dm_bytelane.sv - table-driven scoreboard bench for dm_bytelane.
module tb_dm_bytelane;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        misalign;

  dm_bytelane #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
    .rvalid(rvalid), .rdata(rdata), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        m;
    string       name;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response", rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_rdata"}, rdata, e.d);
        check({e.name, "_misalign"}, {31'h0, misalign}, {31'h0, e.m});
      end
    end
  end

  // Drives one access for one cycle; caller is positioned just after a rising edge
  task automatic do_op(input vec_t v, input string name);
    we = v.we; size = v.size; sign_ext = v.sext; addr = v.addr; wdata = v.wdata;
    pc = pc + 32'd4;
    req = 1'b1;
    if (v.resp) begin
      exp_t e;
      e.d = v.exp_rdata; e.m = v.exp_mis; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic x,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic r, input logic [31:0] ed, input logic em);
    vec_t v;
    v.we = w; v.size = s; v.sext = x; v.addr = a; v.wdata = d;
    v.resp = r; v.exp_rdata = ed; v.exp_mis = em;
    return v;
  endfunction

  task automatic wait_ready(input string name, input int expect_cycles);
    int cnt = 0;
    while (ready !== 1'b1 && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, cnt, expect_cycles);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drain", sb.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; pc = 32'h1000; req = 1'b0; we = 1'b0; size = 2'b10;
    sign_ext = 1'b0; addr = '0; wdata = '0;

    vecs.push_back(mk(1, 2'b10, 0, 32'h10,   32'h12345678, 0, 32'h0,        0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h11,   32'h0,        1, 32'h00000056, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h13,   32'h0,        1, 32'h00000012, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12,   32'h0,        1, 32'h00001234, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,        1, 32'h12345678, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h21,   32'hFFFFFFAB, 0, 32'h0,        0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h20,   32'h0,        1, 32'h0000AB00, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h21,   32'h0,        1, 32'hFFFFFFAB, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h22,   32'h55558001, 0, 32'h0,        0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h22,   32'h0,        1, 32'hFFFF8001, 0));
    vecs.push_back(mk(0, 2'b10, 1, 32'h20,   32'h0,        1, 32'h8001AB00, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h06,   32'h0,        1, 32'h0,        1));
    vecs.push_back(mk(1, 2'b01, 0, 32'h03,   32'hFFFFFFFF, 1, 32'h0,        1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h00,   32'h0,        1, 32'h0,        0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h30,   32'h0,        1, 32'h0,        1));
    vecs.push_back(mk(1, 2'b11, 0, 32'h30,   32'hFFFFFFFF, 1, 32'h0,        1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h30,   32'h0,        1, 32'h0,        0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h1010, 32'hDEADBEEF, 0, 32'h0,        0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0010, 32'h0,        1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h10,   32'h0,        1, 32'h000000EF, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h13,   32'h0,        1, 32'hFFFFFFDE, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10,   32'h0,        1, 32'hFFFFBEEF, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12,   32'h0,        1, 32'h0000DEAD, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h13,   32'h0,        1, 32'h0,        1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0));

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'h0, ready}, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_misalign", {31'h0, misalign}, 32'h0);
    check("reset_rdata", rdata, 32'h0);

    reset_n = 1'b1;
    wait_ready("clear_cycles", 1024);

    do_op(mk(0, 2'b10, 0, 32'hFFC, 32'h0, 1, 32'h0, 0), "load_top_word");
    drain();

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("rdata_hold", rdata, 32'hDEADBEEF);
    check("rvalid_idle", {31'h0, rvalid}, 32'h0);

    // Reset while a load response is on the outputs
    do_op(mk(0, 2'b00, 0, 32'h10, 32'h0, 0, 32'h0, 0), "unused");
    check("pre_reset_rvalid", {31'h0, rvalid}, 32'h1);
    check("pre_reset_rdata", rdata, 32'h000000EF);
    reset_n = 1'b0;
    #1;
    check("async_reset_ready", {31'h0, ready}, 32'h0);
    check("async_reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("async_reset_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    repeat (500) @(posedge clk);
    #1;
    check("midclear_ready", {31'h0, ready}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("midclear_reset_ready", {31'h0, ready}, 32'h0);
    check("midclear_reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("midclear_reset_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_ready("reclear_cycles", 1024);

    do_op(mk(0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h0, 0), "cleared_0x10");
    do_op(mk(0, 2'b10, 0, 32'h20, 32'h0, 1, 32'h0, 0), "cleared_0x20");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
